// File: rtl/if_fetch_if.sv
// Bundle between the fetch stage, the hazard/branch logic, the instruction memory and decode.
// The instruction memory has no backpressure: imem_rd_o with imem_addr_o is a read request that
// is always accepted, and imem_rdata_i carries that word exactly one cycle later.
interface if_fetch_if #(
  parameter int PC_W    = 9,
  parameter int INSTR_W = 32
);
  logic               stall_i;
  logic               flush_i;
  logic [PC_W-1:0]    redirect_pc_i;
  logic               halt_i;
  logic               imem_rd_o;
  logic [PC_W-1:0]    imem_addr_o;
  logic [INSTR_W-1:0] imem_rdata_i;
  logic [PC_W-1:0]    ifid_pc_o;
  logic [INSTR_W-1:0] ifid_instr_o;
  logic               ifid_valid_o;
  logic               halted_o;
  logic [1:0]         fsm_state;

  modport master (
    input  stall_i, flush_i, redirect_pc_i, halt_i, imem_rdata_i,
    output imem_rd_o, imem_addr_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, halted_o, fsm_state
  );

  modport slave (
    output stall_i, flush_i, redirect_pc_i, halt_i, imem_rdata_i,
    input  imem_rd_o, imem_addr_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, halted_o, fsm_state
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads the synchronous instruction memory and fills IF/ID,
// absorbing stalls with a one-entry hold buffer, redirecting on flush and parking on halt.
module if_fetch_stage #(
  parameter int                  PC_W      = 9,
  parameter int                  INSTR_W   = 32,
  parameter logic [PC_W-1:0]     RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = 32'h0000_0013
) (
  input  logic      clk,
  input  logic      reset,
  if_fetch_if.master bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t             state;
  logic [PC_W-1:0]    pc_q;
  logic               pend_valid;
  logic [PC_W-1:0]    pend_pc;
  logic               hold_valid;
  logic [PC_W-1:0]    hold_pc;
  logic [INSTR_W-1:0] hold_instr;
  logic [PC_W-1:0]    ifid_pc;
  logic [INSTR_W-1:0] ifid_instr;
  logic               ifid_valid;
  logic               halted;
  logic               issue;

  assign issue            = (state == RUN) && !bus.stall_i && !bus.flush_i && !reset;
  assign bus.imem_rd_o    = issue;
  assign bus.imem_addr_o  = pc_q;
  assign bus.ifid_pc_o    = ifid_pc;
  assign bus.ifid_instr_o = ifid_instr;
  assign bus.ifid_valid_o = ifid_valid;
  assign bus.halted_o     = halted;
  assign bus.fsm_state    = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
      hold_valid <= 1'b0;
      hold_pc    <= '0;
      hold_instr <= NOP_INSTR;
      state      <= RUN;
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
      halted     <= 1'b0;
    end else if (bus.flush_i && state != HALTED) begin
      // Redirect: anything in flight or held belongs to the wrong path.
      pc_q       <= {bus.redirect_pc_i[PC_W-1:2], 2'b00};
      pend_valid <= 1'b0;
      hold_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
      state      <= RUN;
    end else begin
      if (issue) begin
        pc_q    <= pc_q + PC_W'(4);
        pend_pc <= pc_q;
      end
      pend_valid <= issue;

      if (pend_valid) begin
        if (!bus.stall_i) begin
          ifid_pc    <= pend_pc;
          ifid_instr <= bus.imem_rdata_i;
          ifid_valid <= 1'b1;
        end else begin
          // Memory data is only valid this cycle, so park it until decode frees up.
          hold_valid <= 1'b1;
          hold_pc    <= pend_pc;
          hold_instr <= bus.imem_rdata_i;
        end
      end else if (hold_valid) begin
        if (!bus.stall_i) begin
          ifid_pc    <= hold_pc;
          ifid_instr <= hold_instr;
          ifid_valid <= 1'b1;
          hold_valid <= 1'b0;
        end
      end else if (!bus.stall_i) begin
        ifid_instr <= NOP_INSTR;
        ifid_valid <= 1'b0;
      end

      case (state)
        RUN:     if (bus.halt_i) state <= DRAIN;
        DRAIN: begin
          if (!pend_valid && !hold_valid) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // The hold buffer only fills while stalled, and no read issues while stalled.
  assert property (@(posedge clk) disable iff (reset) !(pend_valid && hold_valid));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus random stall/flush/halt/reset traffic,
// checked cycle by cycle against an in-order fetch-stream model.
module tb_if_fetch_stage;
  localparam int                 PC_W     = 9;
  localparam int                 INSTR_W  = 32;
  localparam logic [INSTR_W-1:0] NOP      = 32'h0000_0013;
  localparam logic [PC_W-1:0]    RST_PC   = 9'h000;
  localparam logic [PC_W-1:0]    WRAP_PC  = 9'h1F8;
  localparam int                 M_RUN    = 0;
  localparam int                 M_DRAIN  = 1;
  localparam int                 M_HALTED = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall;
  logic            flush;
  logic            halt;
  logic [PC_W-1:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();
  if_fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus_w ();

  assign bus.stall_i         = stall;
  assign bus.flush_i         = flush;
  assign bus.halt_i          = halt;
  assign bus.redirect_pc_i   = redirect_pc;
  assign bus_w.stall_i       = stall;
  assign bus_w.flush_i       = flush;
  assign bus_w.halt_i        = halt;
  assign bus_w.redirect_pc_i = redirect_pc;

  if_fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RST_PC), .NOP_INSTR(NOP)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  if_fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(WRAP_PC), .NOP_INSTR(NOP)) u_dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_w)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] a);
    return 32'hA000_0000 | INSTR_W'(a);
  endfunction

  // Instruction memory: data one cycle after a read, garbage otherwise.
  always @(posedge clk) begin
    bus.imem_rdata_i   <= bus.imem_rd_o   ? instr_of(bus.imem_addr_o)   : INSTR_W'($urandom);
    bus_w.imem_rdata_i <= bus_w.imem_rd_o ? instr_of(bus_w.imem_addr_o) : INSTR_W'($urandom);
  end

  // Reference model: fetched-but-undelivered addresses in program order.
  logic [PC_W-1:0]    exp_q[$];
  logic [PC_W-1:0]    m_pc;
  int                 m_mode;
  logic [PC_W-1:0]    m_out_pc;
  logic [INSTR_W-1:0] m_out_instr;
  logic               m_out_valid;
  logic               m_halted;
  bit                 model_known = 1'b0;

  bit                 wrap_cap = 1'b0;
  logic [PC_W-1:0]    wrap_seen[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic s, input logic f, input logic [PC_W-1:0] rp,
                            input logic h, input logic r, input logic rd);
    bit was_empty;
    if (r) begin
      exp_q.delete();
      m_pc        = RST_PC;
      m_mode      = M_RUN;
      m_out_pc    = '0;
      m_out_instr = NOP;
      m_out_valid = 1'b0;
      m_halted    = 1'b0;
      return;
    end
    if (f && m_mode != M_HALTED) begin
      exp_q.delete();
      m_pc        = {rp[PC_W-1:2], 2'b00};
      m_out_instr = NOP;
      m_out_valid = 1'b0;
      m_mode      = M_RUN;
      return;
    end
    was_empty = (exp_q.size() == 0);
    if (!s) begin
      if (exp_q.size() != 0) begin
        m_out_pc    = exp_q.pop_front();
        m_out_instr = instr_of(m_out_pc);
        m_out_valid = 1'b1;
      end else begin
        m_out_instr = NOP;
        m_out_valid = 1'b0;
      end
    end
    if (rd) begin
      exp_q.push_back(m_pc);
      m_pc = PC_W'((int'(m_pc) + 4) % 512);
    end
    if (m_mode == M_RUN && h) m_mode = M_DRAIN;
    else if (m_mode == M_DRAIN && was_empty) begin
      m_mode   = M_HALTED;
      m_halted = 1'b1;
    end
  endtask

  // Driver: apply one cycle of inputs, check strobe/address, clock, check IF/ID.
  task automatic step(input logic s, input logic f, input logic [PC_W-1:0] rp,
                      input logic h, input logic r);
    logic exp_rd;
    stall = s; flush = f; redirect_pc = rp; halt = h; reset = r;
    #1;
    exp_rd = !r && (m_mode == M_RUN) && !s && !f;
    check("imem_rd", bus.imem_rd_o, exp_rd);
    if (model_known) check("imem_addr", bus.imem_addr_o, m_pc);
    @(posedge clk);
    model_edge(s, f, rp, h, r, exp_rd);
    if (r) model_known = 1'b1;
    #1;
    check("ifid_pc", bus.ifid_pc_o, m_out_pc);
    check("ifid_instr", bus.ifid_instr_o, m_out_instr);
    check("ifid_valid", bus.ifid_valid_o, m_out_valid);
    check("halted", bus.halted_o, m_halted);
    if (wrap_cap && bus_w.ifid_valid_o) wrap_seen.push_back(bus_w.ifid_pc_o);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    stall = 1'b0; flush = 1'b0; halt = 1'b0; redirect_pc = '0; reset = 1'b1;
    @(posedge clk); #1;

    // Reset two cycles, then free run (wrap instance observed in parallel)
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    wrap_cap = 1'b1;
    run(3);
    wrap_cap = 1'b0;
    check("wrap_count", (wrap_seen.size() >= 2) ? 64'd1 : 64'd0, 64'd1);
    if (wrap_seen.size() >= 2) begin
      check("wrap_pc0", wrap_seen[0], 9'h1F8);
      check("wrap_pc1", wrap_seen[1], 9'h1FC);
    end
    run(1);
    check("wrap_pc2", bus_w.ifid_pc_o, 9'h000);
    check("wrap_valid2", bus_w.ifid_valid_o, 1'b1);

    // Stall three cycles while a read returns, then release
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    run(3);

    // Flush while stalled with the hold buffer full
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 9'h043, 1'b0, 1'b0);
    run(4);

    // Halt with a fetch in flight, flush ignored while halted, then reset
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    run(6);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    run(4);
    step(1'b0, 1'b1, 9'h080, 1'b0, 1'b0);
    run(2);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    run(3);

    // Reset mid-stall with the hold buffer full
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    run(4);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6,
           PC_W'($urandom_range(0, 511)), $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
